// File: rtl/cpu19_pkg.sv
// Shared types and constants for the 19-bit CPU instruction-cycle controller:
// phase codes, opcodes, fetch T-indices and the execute-length table.
package cpu19_pkg;

  typedef enum logic [2:0] {
    PH_IDLE     = 3'd0,
    PH_FETCH    = 3'd1,
    PH_DECODE   = 3'd2,
    PH_INDIRECT = 3'd3,
    PH_EXECUTE  = 3'd4,
    PH_INTR     = 3'd5,
    PH_HALT     = 3'd6
  } phase_t;

  localparam int CPU_NUM_T  = 16;
  localparam int CPU_OPC_W  = 5;
  localparam int CPU_EXEC_W = 4;

  localparam logic [4:0] OPC_NOP = 5'h00;
  localparam logic [4:0] OPC_LDA = 5'h01;
  localparam logic [4:0] OPC_STA = 5'h02;
  localparam logic [4:0] OPC_ADD = 5'h03;
  localparam logic [4:0] OPC_JMP = 5'h04;
  localparam logic [4:0] OPC_MUL = 5'h05;
  localparam logic [4:0] OPC_CLR = 5'h06;
  localparam logic [4:0] OPC_HLT = 5'h1F;

  localparam int INTR_CYC   = 3;
  localparam int T_FETCH_AR = 0;
  localparam int T_FETCH_IR = 1;

  // Execute cycles per opcode; a zero entry is stretched to one cycle by the controller.
  function automatic logic [3:0] exec_len_lut(input logic [4:0] opc);
    case (opc)
      OPC_NOP: return 4'd1;
      OPC_LDA: return 4'd3;
      OPC_STA: return 4'd2;
      OPC_ADD: return 4'd3;
      OPC_JMP: return 4'd1;
      OPC_MUL: return 4'd15;
      OPC_CLR: return 4'd0;
      OPC_HLT: return 4'd1;
      default: return 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/exec_len_rom.sv
// Combinational opcode -> execute-cycle-count lookup backed by the cpu19_pkg table.
module exec_len_rom
  import cpu19_pkg::*;
#(
  parameter int OPC_W  = CPU_OPC_W,
  parameter int EXEC_W = CPU_EXEC_W
) (
  input  logic [OPC_W-1:0]  i_opcode,
  output logic [EXEC_W-1:0] o_exec_len
);

  assign o_exec_len = EXEC_W'(exec_len_lut(CPU_OPC_W'(i_opcode)));

endmodule

// File: rtl/instr_cycle_ctrl.sv
// Instruction-cycle controller: phase FSM, execute counter, watchdog and, with
// SC_ONEHOT_CHECK_EN defined, a sequence-counter one-hot/index checker.
module instr_cycle_ctrl
  import cpu19_pkg::*;
#(
  parameter int NUM_T  = CPU_NUM_T,
  parameter int OPC_W  = CPU_OPC_W,
  parameter int EXEC_W = CPU_EXEC_W
) (
  input  logic             i_clk,
  input  logic             i_clr_n,
  input  logic [NUM_T-1:0] i_t_state,
  input  logic             i_start,
  input  logic [OPC_W-1:0] i_opcode,
  input  logic             i_ind,
  input  logic             i_exec_done,
  input  logic             i_irq,
  input  logic             i_ien,
  output logic             o_sc_clr,
  output logic             o_sc_en,
  output logic [2:0]       o_phase,
  output logic             o_ld_ar,
  output logic             o_mem_rd,
  output logic             o_ld_ir,
  output logic             o_inc_pc,
  output logic             o_irq_ack,
  output logic             o_halted,
  output logic             o_seq_err
);

  localparam logic [2:0] S_IDLE     = PH_IDLE;
  localparam logic [2:0] S_FETCH    = PH_FETCH;
  localparam logic [2:0] S_DECODE   = PH_DECODE;
  localparam logic [2:0] S_INDIRECT = PH_INDIRECT;
  localparam logic [2:0] S_EXECUTE  = PH_EXECUTE;
  localparam logic [2:0] S_INTR     = PH_INTR;
  localparam logic [2:0] S_HALT     = PH_HALT;

  logic [2:0]        r_phase;
  logic [EXEC_W-1:0] r_exec_len;
  logic [EXEC_W-1:0] r_ec;
  logic [1:0]        r_ic;
  logic              r_ld_ar, r_mem_rd, r_ld_ir, r_inc_pc, r_irq_ack, r_halted, r_seq_err;

  logic [EXEC_W-1:0] w_rom_len;
  logic [EXEC_W-1:0] w_len_eff;
  logic [2:0]        w_next;
  logic              w_exec_end, w_intr_end, w_ending, w_running, w_wdog;
  logic              w_sc_clr, w_sc_en, w_fetch_t1, w_chk_err;

  exec_len_rom #(
    .OPC_W (OPC_W),
    .EXEC_W(EXEC_W)
  ) u_exec_len_rom (
    .i_opcode  (i_opcode),
    .o_exec_len(w_rom_len)
  );

  assign w_len_eff  = (r_exec_len == '0) ? EXEC_W'(1) : r_exec_len;
  assign w_exec_end = (r_phase == S_EXECUTE) &&
                      (i_exec_done || (r_ec == w_len_eff - EXEC_W'(1)));
  assign w_intr_end = (r_phase == S_INTR) && (r_ic == 2'(INTR_CYC - 1));
  assign w_ending   = w_exec_end || w_intr_end;
  assign w_running  = (r_phase != S_IDLE) && (r_phase != S_HALT);
  // A counter reaching its last T-state without an end means the sequence ran away.
  assign w_wdog     = w_running && i_t_state[NUM_T-1] && !w_ending;

  // Counter controls are decoded, not registered, so the clear lands on the very next edge.
  assign w_sc_clr   = !w_running || w_ending || w_wdog;
  assign w_sc_en    = w_running && !w_sc_clr;
  assign w_fetch_t1 = (r_phase == S_FETCH) && i_t_state[T_FETCH_AR] && !w_sc_clr;

  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    w_next = r_phase;
    if (w_wdog) begin
      w_next = S_FETCH;
    end else begin
      case (r_phase)
        S_IDLE, S_HALT: if (i_start) w_next = S_FETCH;
        S_FETCH:        if (i_t_state[T_FETCH_IR]) w_next = S_DECODE;
        S_DECODE: begin
          if (i_opcode == OPC_HLT) w_next = S_HALT;
          else if (i_ind)          w_next = S_INDIRECT;
          else                     w_next = S_EXECUTE;
        end
        S_INDIRECT:     w_next = S_EXECUTE;
        S_EXECUTE:      if (w_exec_end) w_next = (i_irq && i_ien) ? S_INTR : S_FETCH;
        S_INTR:         if (w_intr_end) w_next = S_FETCH;
        default:        w_next = S_IDLE;
      endcase
    end
  end

  // Strobes are registered from the next-state view so each lands in its own T-state cycle.
  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_phase    <= S_IDLE;
      r_exec_len <= '0;
      r_ec       <= '0;
      r_ic       <= '0;
      r_ld_ar    <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_ld_ir    <= 1'b0;
      r_inc_pc   <= 1'b0;
      r_irq_ack  <= 1'b0;
      r_halted   <= 1'b0;
      r_seq_err  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_phase   <= w_next;
      r_ec      <= (r_phase == S_EXECUTE && !w_exec_end) ? r_ec + EXEC_W'(1) : '0;
      r_ic      <= (r_phase == S_INTR && !w_intr_end) ? r_ic + 2'd1 : 2'd0;
      if (r_phase == S_DECODE) r_exec_len <= w_rom_len;
      r_ld_ar   <= (w_next == S_FETCH && w_sc_clr) || (w_next == S_INDIRECT);
      r_mem_rd  <= w_fetch_t1 || (w_next == S_INDIRECT);
      r_ld_ir   <= w_fetch_t1;
      r_inc_pc  <= w_fetch_t1;
      r_irq_ack <= (w_next == S_INTR) && (r_phase != S_INTR);
      r_halted  <= (w_next == S_HALT);
      r_seq_err <= r_seq_err || w_wdog || w_chk_err;
    end
  end

`ifdef SC_ONEHOT_CHECK_EN
  logic [$clog2(NUM_T)-1:0] r_exp_idx;

  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n)      r_exp_idx <= '0;
    else if (w_sc_clr) r_exp_idx <= '0;
    else if (w_sc_en)  r_exp_idx <= r_exp_idx + 1'b1;
  end

  assign w_chk_err = w_sc_en && (($countones(i_t_state) != 1) ||
                                 (i_t_state != (NUM_T'(1) << r_exp_idx)));
`else
  logic w_unused_t;

  assign w_chk_err  = 1'b0;
  // Middle T-states only matter to the checker.
  assign w_unused_t = ^i_t_state[NUM_T-2:T_FETCH_IR+1];
`endif

  assign o_sc_clr  = w_sc_clr;
  assign o_sc_en   = w_sc_en;
  assign o_phase   = r_phase;
  assign o_ld_ar   = r_ld_ar;
  assign o_mem_rd  = r_mem_rd;
  assign o_ld_ir   = r_ld_ir;
  assign o_inc_pc  = r_inc_pc;
  assign o_irq_ack = r_irq_ack;
  assign o_halted  = r_halted;
  assign o_seq_err = r_seq_err;

endmodule

// File: tb/tb_instr_cycle_ctrl.sv
// Scoreboard bench for instr_cycle_ctrl: models the sequence counter, queues the
// expected per-cycle output vector as stimulus is driven, compares on the falling edge.
module tb_instr_cycle_ctrl;
  import cpu19_pkg::*;

  localparam logic [5:0] S_AR  = 6'b100000;
  localparam logic [5:0] S_RD  = 6'b010000;
  localparam logic [5:0] S_IR  = 6'b001000;
  localparam logic [5:0] S_PC  = 6'b000100;
  localparam logic [5:0] S_ACK = 6'b000010;
  localparam logic [5:0] S_HLT = 6'b000001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] t_state;
  logic        start, ind, exec_done, irq, ien;
  logic [4:0]  opcode;
  logic        sc_clr, sc_en, ld_ar, mem_rd, ld_ir, inc_pc, irq_ack, halted, seq_err;
  logic [2:0]  phase;

  logic [3:0]  cnt;
  logic        force_en;
  logic        exp_err;
  logic [11:0] obs;

  int          n_checks = 0;
  int          n_fail   = 0;
  string       q_tag[$];
  logic [11:0] q_exp[$];
  string       m_tag;
  logic [11:0] m_exp;

  always #5 clk = ~clk;

  instr_cycle_ctrl dut (
    .i_clk      (clk),
    .i_clr_n    (rst_n),
    .i_t_state  (t_state),
    .i_start    (start),
    .i_opcode   (opcode),
    .i_ind      (ind),
    .i_exec_done(exec_done),
    .i_irq      (irq),
    .i_ien      (ien),
    .o_sc_clr   (sc_clr),
    .o_sc_en    (sc_en),
    .o_phase    (phase),
    .o_ld_ar    (ld_ar),
    .o_mem_rd   (mem_rd),
    .o_ld_ir    (ld_ir),
    .o_inc_pc   (inc_pc),
    .o_irq_ack  (irq_ack),
    .o_halted   (halted),
    .o_seq_err  (seq_err)
  );

  // Sequence counter model; force_en pins it to T15 when it would show T8.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= 4'd0;
    else if (sc_clr) cnt <= 4'd0;
    else if (sc_en)  cnt <= cnt + 4'd1;
  end

  assign t_state = (force_en && cnt == 4'd8) ? 16'h8000 : (16'h0001 << cnt);
  assign obs = {phase, sc_clr, sc_en, ld_ar, mem_rd, ld_ir, inc_pc, irq_ack, halted, seq_err};

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [11:0] ev(input logic [2:0] ph, input logic clr, input logic en,
                                     input logic [5:0] strb);
    return {ph, clr, en, strb, exp_err};
  endfunction

  task automatic cyc(input string tag, input logic [11:0] e);
    q_tag.push_back(tag);
    q_exp.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run_fetch(input logic [4:0] opc, input logic ind_b, input logic irq_at_t1,
                           input string tag);
    cyc({tag, ".t0"}, ev(PH_FETCH, 1'b0, 1'b1, S_AR));
    if (irq_at_t1) begin
      irq = 1'b1;
      ien = 1'b1;
    end
    cyc({tag, ".t1"}, ev(PH_FETCH, 1'b0, 1'b1, S_RD | S_IR | S_PC));
    opcode = opc;
    ind    = ind_b;
    cyc({tag, ".dec"}, ev(PH_DECODE, 1'b0, 1'b1, 6'b0));
    ind = 1'b0;
  endtask

  always @(negedge clk) begin
    if (q_exp.size() != 0) begin
      m_tag = q_tag.pop_front();
      m_exp = q_exp.pop_front();
      check(m_tag, 32'(obs), 32'(m_exp));
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    start = 1'b0; opcode = 5'd0; ind = 1'b0; exec_done = 1'b0;
    irq = 1'b0; ien = 1'b0; force_en = 1'b0; exp_err = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 32'(obs), 32'(ev(PH_IDLE, 1'b1, 1'b0, 6'b0)));
    rst_n = 1'b1;

    cyc("idle", ev(PH_IDLE, 1'b1, 1'b0, 6'b0));
    start = 1'b1;
    cyc("idle.start", ev(PH_IDLE, 1'b1, 1'b0, 6'b0));
    start = 1'b0;

    // Direct three-cycle op: T3..T5, clear on T5 only.
    run_fetch(OPC_LDA, 1'b0, 1'b0, "lda");
    cyc("lda.e0", ev(PH_EXECUTE, 1'b0, 1'b1, 6'b0));
    cyc("lda.e1", ev(PH_EXECUTE, 1'b0, 1'b1, 6'b0));
    cyc("lda.e2", ev(PH_EXECUTE, 1'b1, 1'b0, 6'b0));

    // Indirect op with early completion in its first execute cycle.
    run_fetch(OPC_STA, 1'b1, 1'b0, "sta");
    cyc("sta.ind", ev(PH_INDIRECT, 1'b0, 1'b1, S_RD | S_AR));
    exec_done = 1'b1;
    cyc("sta.e0", ev(PH_EXECUTE, 1'b1, 1'b0, 6'b0));
    exec_done = 1'b0;

    // Interrupt raised at T1 of a one-cycle op waits for the end.
    run_fetch(OPC_JMP, 1'b0, 1'b1, "irq");
    cyc("irq.e0", ev(PH_EXECUTE, 1'b1, 1'b0, 6'b0));
    cyc("irq.i1", ev(PH_INTR, 1'b0, 1'b1, S_ACK));
    irq = 1'b0;
    cyc("irq.i2", ev(PH_INTR, 1'b0, 1'b1, 6'b0));
    cyc("irq.i3", ev(PH_INTR, 1'b1, 1'b0, 6'b0));

    // Masked request, zero-length op, exec_done coinciding with the last count.
    irq = 1'b1;
    ien = 1'b0;
    run_fetch(OPC_CLR, 1'b0, 1'b0, "clr");
    exec_done = 1'b1;
    cyc("clr.e0", ev(PH_EXECUTE, 1'b1, 1'b0, 6'b0));
    exec_done = 1'b0;
    irq = 1'b0;

    // Halt and restart; start stays high through the next fetch and must be ignored.
    run_fetch(OPC_HLT, 1'b0, 1'b0, "hlt");
    cyc("hlt.h0", ev(PH_HALT, 1'b1, 1'b0, S_HLT));
    cyc("hlt.h1", ev(PH_HALT, 1'b1, 1'b0, S_HLT));
    start = 1'b1;
    cyc("hlt.start", ev(PH_HALT, 1'b1, 1'b0, S_HLT));

    // Fifteen-cycle op; counter forced to T15 at ec=5 trips the watchdog.
    run_fetch(OPC_MUL, 1'b0, 1'b0, "wdog");
    start    = 1'b0;
    force_en = 1'b1;
    for (int i = 0; i < 5; i++) cyc("wdog.e", ev(PH_EXECUTE, 1'b0, 1'b1, 6'b0));
    cyc("wdog.t15", ev(PH_EXECUTE, 1'b1, 1'b0, 6'b0));
    force_en = 1'b0;
    exp_err  = 1'b1;
    run_fetch(OPC_JMP, 1'b0, 1'b0, "post");
    cyc("post.e0", ev(PH_EXECUTE, 1'b1, 1'b0, 6'b0));

    // Asynchronous reset in the middle of T4.
    run_fetch(OPC_LDA, 1'b0, 1'b0, "ar");
    cyc("ar.e0", ev(PH_EXECUTE, 1'b0, 1'b1, 6'b0));
    #2 rst_n = 1'b0;
    #1;
    exp_err = 1'b0;
    check("ar.reset", 32'(obs), 32'(ev(PH_IDLE, 1'b1, 1'b0, 6'b0)));
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc("ar.idle", ev(PH_IDLE, 1'b1, 1'b0, 6'b0));
    start = 1'b1;
    cyc("rec.start", ev(PH_IDLE, 1'b1, 1'b0, 6'b0));
    start = 1'b0;
    cyc("rec.t0", ev(PH_FETCH, 1'b0, 1'b1, S_AR));
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
